// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam int unsigned IMEM_BYTES_DEF  = 23;
   localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
   localparam int unsigned PC_STEP_DEF     = 2;

   typedef logic [15:0] inst_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem address and
// registers each fetched instruction into an IF/ID holding register
// with a valid/ready handshake towards decode.
//
// state | meaning
// IDLE  | out of reset, waiting for start; no fetches
// RUN   | fetching one instruction per free holding-register slot
// DRAIN | stop fetching (end of memory or halt opcode), let decode take the last one
// HALT  | stopped, PC frozen; only a branch or reset leaves
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned IMEM_BYTES  = IMEM_BYTES_DEF,
   parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF,
   parameter int unsigned PC_STEP     = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] pc,
   input  logic [3:0]  one,
   input  logic [3:0]  two,
   input  logic [3:0]  three,
   input  logic [3:0]  four,
   output inst_t       inst_out,
   output logic [15:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic        halted,
   output logic [15:0] fetch_count
);

   localparam logic [15:0] LAST_PC = 16'(IMEM_BYTES - 2);
   localparam logic [15:0] STEP    = 16'(PC_STEP);

   fetch_state_t state;
   logic         in_range;
   logic         slot_free;
   logic         load;
   logic         consume;
   logic         redirect;

   // Fetch qualification: a branch always wins over a load in the same cycle.
   assign in_range  = (pc <= LAST_PC);
   assign slot_free = !inst_valid || inst_ready;
   assign redirect  = br_taken && (state != IDLE);
   assign load      = (state == RUN) && slot_free && in_range && !br_taken;
   assign consume   = inst_valid && inst_ready;

   // Sequencer state, PC, holding register and fetch counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= '0;
         inst_out    <= '0;
         inst_pc     <= '0;
         inst_valid  <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else if (redirect) begin
         // Bit 0 of the target is dropped so fetches stay instruction-aligned.
         pc         <= br_target & 16'hFFFE;
         inst_valid <= 1'b0;
         state      <= RUN;
         halted     <= 1'b0;
      end else begin
         if (load) begin
            inst_out   <= {one, two, three, four};
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + STEP;
            if (fetch_count != 16'hFFFF) begin
               fetch_count <= fetch_count + 16'd1;
            end
         end else if (consume) begin
            inst_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               // The halt instruction itself is still delivered before draining.
               if ((load && (one == HALT_OPCODE)) || !in_range) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (slot_free) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
